rv_muldiv_unit: RTL
===================

// Module: rv_muldiv_unit
// PURPOSE
//   Iterative RV32M/RV64M multiply/divide unit for the EX stage of the 5-stage pipeline.
//   The EX stage launches MUL*/DIV*/REM* ops with a valid/ready handshake.
//   The unit computes UNROLL result bits per cycle and returns a tagged result.
//   The hazard unit holds IF/ID/EX (stall) while an op is outstanding.
//   Successor to the single-cycle ALU path: parametrised in width and throughput, with early-out special cases.
// PARAMETERS
//   XLEN    32  operand/result width; 32 or 64
//   UNROLL  1   bits resolved per CALC cycle; 1, 2 or 4; must divide XLEN
//   TAGW    5   width of destination-register tag (rd)
// PORTS
//   clk        in   1     clock, rising edge
//   rst        in   1     asynchronous reset, active-low (asserted when 0)
//   in_valid   in   1     EX presents an M-extension op
//   in_ready   out  1     unit can accept; transfer on in_valid & in_ready at rising edge
//   in_funct3  in   3     RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   in_rs1     in   XLEN  operand A (dividend / multiplicand)
//   in_rs2     in   XLEN  operand B (divisor / multiplier)
//   in_rd      in   TAGW  destination tag, returned unchanged
//   flush      in   1     synchronous abort (branch/jump redirect)
//   busy       out  1     op accepted and result not yet consumed (state != IDLE)
//   out_valid  out  1     result valid; held until out_ready
//   out_ready  in   1     consumer (EX/MEM reg) takes result
//   out_result out  XLEN  result
//   out_rd     out  TAGW  tag of result
// BEHAVIOUR
//   Reset (rst=0, async)
//     - State IDLE; all datapath registers zero.
//     - Outputs: in_ready=1, busy=0, out_valid=0, out_result=0, out_rd=0.
//   FSM: IDLE -> CALC -> FIX -> DONE -> IDLE. N = XLEN/UNROLL.
//     - IDLE: on accept, latch the operands as absolute values for signed ops, record the result sign, latch tag.
//       Go to CALC, or go to FIX directly on a special case.
//     - CALC: N cycles; counter counts N-1 down to 0.
//       - Multiply: radix-2^UNROLL shift-add over a 2*XLEN-bit product.
//       - Divide: restoring divide, UNROLL quotient bits per cycle.
//     - FIX: one cycle.
//       - Apply sign correction (two's-complement negate when the sign flag is set).
//       - Select the low/high product, quotient or remainder.
//       - Register out_result and out_rd; go to DONE.
//     - DONE: out_valid=1; out_result and out_rd stable until the cycle with out_ready=1, then go to IDLE.
//   Latency (accept at edge E0)
//     - Normal op: CALC on edges E1..EN, FIX at E(N+1); out_valid high after E(N+1).
//       Example: XLEN=32, UNROLL=1 gives 33 edges.
//     - Special case: FIX at E1; out_valid high after E1.
//   Sign rules
//     - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU, DIVU, REMU: unsigned.
//     - DIV quotient sign = sign(rs1) XOR sign(rs2); REM sign = sign(rs1).
//   Special cases (RISC-V spec; no exception)
//     - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = rs1.
//     - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV result = rs1; REM result = 0.
//     - Multiply with either operand = 0: result 0 via the early-out path.
//   Handshake
//     - in_ready = (state==IDLE) | (state==DONE & out_ready), so back-to-back ops have no bubble.
//     - On simultaneous out handshake and accept: the next op is latched and the state goes to CALC or FIX, not IDLE.
//     - in_valid is ignored while in_ready=0; inputs need only be stable in the accept cycle.
//   Flush
//     - Any state goes to IDLE at the next edge; out_valid=0 after that edge; the in-flight result is discarded.
//     - flush overrides a same-cycle accept: in_ready is forced 0 while flush=1.
//     - flush in DONE coincident with out_ready: the result transfer still counts. The consumer sees out_valid&out_ready, and the unit returns to IDLE.
//   Reset mid-operation: immediate return to the reset state; no partial result is emitted.
//   Widths
//     - Product accumulator 2*XLEN bits; divider remainder XLEN+1 bits.
//     - All negation is modulo 2^XLEN; no saturation.
// TESTING
//   1. MUL rs1=7, rs2=-3 (XLEN=32, UNROLL=1) -> out_result=0xFFFFFFEB, out_valid 33 edges after accept.
//   2. MULH/MULHSU/MULHU with rs1=0x80000000, rs2=0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF.
//   3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/0 -> 0xFFFFFFFF and REMU -> 0xFFFFFFFF, each valid after 1 edge.
//   4. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; early-out latency of 1 edge.
//   5. out_ready held 0 for 5 cycles in DONE -> result and out_rd stable; then out_ready=1 with in_valid=1 -> next op accepted in the same cycle with no idle cycle.
//   6. flush at CALC cycle 10 -> IDLE next edge, no out_valid; rst=0 pulse mid-CALC -> all outputs at reset values immediately. Repeat tests 1-3 with UNROLL=4 (latency 9) and XLEN=64.

Source files
------------

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// UNROLL result bits per cycle, with early-out handling of zero/overflow operands.
module rv_muldiv_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned TAGW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [TAGW-1:0] in_rd,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_rd
);

  localparam int unsigned N  = XLEN / UNROLL;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_next;

  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              neg;
  logic [XLEN-1:0]   opa, opb, rem, rem_step;
  logic [2*XLEN-1:0] acc, acc_step;
  logic [TAGW-1:0]   tag;
  logic              accept;

  logic            is_div, sgn_a, sgn_b, a_neg, b_neg, in_neg;
  logic            div0, ovf, mul0, special;
  logic [XLEN-1:0] abs_a, abs_b;

  logic [XLEN:0]     shifted, trial;
  logic [XLEN:0]     hi;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, result;

  assign in_ready  = ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    is_div  = in_funct3[2];
    sgn_a   = (in_funct3 == 3'b001) | (in_funct3 == 3'b010) |
              (in_funct3 == 3'b100) | (in_funct3 == 3'b110);
    sgn_b   = (in_funct3 == 3'b001) | (in_funct3 == 3'b100) | (in_funct3 == 3'b110);
    a_neg   = sgn_a & in_rs1[XLEN-1];
    b_neg   = sgn_b & in_rs2[XLEN-1];
    abs_a   = a_neg ? -in_rs1 : in_rs1;
    abs_b   = b_neg ? -in_rs2 : in_rs2;
    in_neg  = (in_funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
    div0    = is_div & (in_rs2 == '0);
    ovf     = is_div & ~in_funct3[0] & (in_rs1 == MIN_NEG) & (in_rs2 == '1);
    mul0    = ~is_div & ((in_rs1 == '0) | (in_rs2 == '0));
    special = div0 | ovf | mul0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? FIX : CALC;
      CALC: if (cnt == '0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = accept ? (special ? FIX : CALC) : IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // acc low half doubles as multiplier shift register (mul) or dividend/quotient (div)
  always_comb begin
    acc_step = acc;
    rem_step = rem;
    shifted  = '0;
    trial    = '0;
    hi       = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (op[2]) begin
        shifted  = {rem_step, acc_step[XLEN-1]};
        trial    = shifted - {1'b0, opb};
        rem_step = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        acc_step[XLEN-1:0] = {acc_step[XLEN-2:0], ~trial[XLEN]};
      end else begin
        hi       = {1'b0, acc_step[2*XLEN-1:XLEN]} + {1'b0, (acc_step[0] ? opa : '0)};
        acc_step = {hi, acc_step[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rmd  = neg ? -rem : rem;
    case (op)
      3'b000:                 result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = quo;
      default:                result = rmd;
    endcase
  end

  // Special cases preload acc/rem with the final answer and clear neg, so FIX needs no extra path
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      op         <= '0;
      neg        <= 1'b0;
      opa        <= '0;
      opb        <= '0;
      rem        <= '0;
      acc        <= '0;
      tag        <= '0;
      out_result <= '0;
      out_rd     <= '0;
    end else begin
      if (accept) begin
        op  <= in_funct3;
        tag <= in_rd;
        cnt <= CW'(N - 1);
        opa <= abs_a;
        opb <= abs_b;
        rem <= '0;
        neg <= in_neg;
        acc <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
        if (special) begin
          neg <= 1'b0;
          if (mul0) begin
            acc <= '0;
          end else if (div0) begin
            acc <= {{XLEN{1'b0}}, {XLEN{1'b1}}};
            rem <= in_rs1;
          end else begin
            acc <= {{XLEN{1'b0}}, in_rs1};
          end
        end
      end else if (state == CALC) begin
        acc <= acc_step;
        rem <= rem_step;
        cnt <= cnt - 1'b1;
      end
      if ((state == FIX) && !flush) begin
        out_result <= result;
        out_rd     <= tag;
      end
    end
  end

endmodule
